keypad_scanner: RTL

Scans a 4x4 matrix hex keypad, the input-side counterpart of the 4-digit seven-segment output driver. It drives the keypad columns active-low one at a time and synchronises the row returns. Each full sweep is debounced, and every accepted key press is emitted as a 4-bit hex code with a one-cycle valid strobe. It also maintains a 4-digit shift register (newest key in the lowest nibble) that wires directly to the seven-segment driver's in3..in0.

---
 rtl/keypad_scanner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: walks the columns active-low, debounces whole sweeps
// and shifts each accepted key into a 4-digit display register.
module keypad_scanner #(
   parameter int SCAN_DIV = 4096,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   output logic [15:0] digits
);

   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DB_PRESS = 2'd1;
   localparam logic [1:0] PRESSED  = 2'd2;
   localparam logic [1:0] DB_REL   = 2'd3;

   logic [3:0]    rowMeta_q, rowSync_q;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    idx_q, idx_d;
   logic [1:0]    hitCnt_q, hitCnt_d;
   logic [3:0]    hitCode_q, hitCode_d;
   logic [1:0]    state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    keyCode_q, keyCode_d;
   logic          keyValid_q, keyValid_d;
   logic [15:0]   digits_q, digits_d;

   logic          sampleTick, sweepEnd, accept, isSingle, isCand;
   logic [1:0]    colCnt, colRow, sweepCnt;
   logic [3:0]    sweepCode;

   function automatic logic [3:0] keyMap(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'd0:    keyMap = 4'h1;
         4'd1:    keyMap = 4'h2;
         4'd2:    keyMap = 4'h3;
         4'd3:    keyMap = 4'hA;
         4'd4:    keyMap = 4'h4;
         4'd5:    keyMap = 4'h5;
         4'd6:    keyMap = 4'h6;
         4'd7:    keyMap = 4'hB;
         4'd8:    keyMap = 4'h7;
         4'd9:    keyMap = 4'h8;
         4'd10:   keyMap = 4'h9;
         4'd11:   keyMap = 4'hC;
         4'd12:   keyMap = 4'hE;
         4'd13:   keyMap = 4'h0;
         4'd14:   keyMap = 4'hF;
         default: keyMap = 4'hD;
      endcase
   endfunction

   assign sampleTick = (div_q == DIV_LAST);
   assign sweepEnd   = sampleTick && (idx_q == 2'd3);

   // Hit count for the active column saturates at 2, which is all MULTI needs.
   always_comb begin
      colCnt = 2'd0;
      colRow = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!rowSync_q[r]) begin
            if (colCnt != 2'd2) colCnt = colCnt + 2'd1;
            colRow = 2'(r);
         end
      end
      if (hitCnt_q == 2'd2 || colCnt == 2'd2 || (hitCnt_q == 2'd1 && colCnt == 2'd1))
         sweepCnt = 2'd2;
      else
         sweepCnt = hitCnt_q | colCnt;
      sweepCode = (hitCnt_q == 2'd1) ? hitCode_q : keyMap(colRow, idx_q);
   end

   always_comb begin
      div_d     = sampleTick ? '0 : div_q + DW'(1);
      idx_d     = sampleTick ? idx_q + 2'd1 : idx_q;
      hitCnt_d  = hitCnt_q;
      hitCode_d = hitCode_q;
      if (sweepEnd) begin
         hitCnt_d  = 2'd0;
         hitCode_d = 4'h0;
      end else if (sampleTick) begin
         hitCnt_d  = sweepCnt;
         hitCode_d = sweepCode;
      end
   end

   assign isSingle = (sweepCnt == 2'd1);
   assign isCand   = isSingle && (sweepCode == cand_q);

   // Debounce FSM only moves on the cycle that closes a full sweep.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      if (sweepEnd) begin
         case (state_q)
            IDLE: begin
               if (isSingle) begin
                  cand_d = sweepCode;
                  cnt_d  = CNT_ONE;
                  if (DEBOUNCE == 1) begin
                     accept  = 1'b1;
                     state_d = PRESSED;
                  end else begin
                     state_d = DB_PRESS;
                  end
               end
            end
            DB_PRESS: begin
               if (isCand) begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_d == CNT_LAST) begin
                     accept  = 1'b1;
                     state_d = PRESSED;
                  end
               end else if (isSingle) begin
                  cand_d = sweepCode;
                  cnt_d  = CNT_ONE;
               end else begin
                  state_d = IDLE;
               end
            end
            PRESSED: begin
               if (!isCand) begin
                  cnt_d   = CNT_ONE;
                  state_d = (DEBOUNCE == 1) ? IDLE : DB_REL;
               end
            end
            default: begin
               if (isCand) begin
                  state_d = PRESSED;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_d == CNT_LAST) state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      keyValid_d = accept;
      keyCode_d  = accept ? cand_d : keyCode_q;
      digits_d   = accept ? {digits_q[11:0], cand_d} : digits_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rowMeta_q  <= 4'hF;
         rowSync_q  <= 4'hF;
         div_q      <= '0;
         idx_q      <= 2'd0;
         hitCnt_q   <= 2'd0;
         hitCode_q  <= 4'h0;
         state_q    <= IDLE;
         cand_q     <= 4'h0;
         cnt_q      <= '0;
         keyCode_q  <= 4'h0;
         keyValid_q <= 1'b0;
         digits_q   <= 16'h0000;
      end else begin
         rowMeta_q  <= row;
         rowSync_q  <= rowMeta_q;
         div_q      <= div_d;
         idx_q      <= idx_d;
         hitCnt_q   <= hitCnt_d;
         hitCode_q  <= hitCode_d;
         state_q    <= state_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         keyCode_q  <= keyCode_d;
         keyValid_q <= keyValid_d;
         digits_q   <= digits_d;
      end
   end

   assign col       = ~(4'b0001 << idx_q);
   assign key_code  = keyCode_q;
   assign key_valid = keyValid_q;
   assign key_held  = (state_q == PRESSED) || (state_q == DB_REL);
   assign digits    = digits_q;

endmodule
